// File: rtl/xgmii_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xgmii_pkg
// Description : Shared XGMII / Clause-49 64b/66b constants and types, used by
//               the TX MAC, the 64b/66b encoder and the future decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package xgmii_pkg;

  // XGMII control characters
  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERROR = 8'hFE;
  localparam logic [7:0] XGMII_SEQ   = 8'h9C;

  // 64b/66b sync headers
  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  // Block type field values
  localparam logic [7:0] BT_CTRL = 8'h1E;
  localparam logic [7:0] BT_S0   = 8'h78;
  localparam logic [7:0] BT_S4   = 8'h33;
  // Terminate block types indexed by the /T/ lane (element 0 = /T/ in lane 0)
  localparam logic [7:0][7:0] BT_TERM = {8'hFF, 8'hE1, 8'hD2, 8'hCC,
                                         8'hB4, 8'hAA, 8'h99, 8'h87};

  // 7-bit 64b/66b control codes
  localparam logic [6:0] CC_IDLE  = 7'h00;
  localparam logic [6:0] CC_ERROR = 7'h1E;

  // Classification of one 8-lane column
  typedef enum logic [2:0] {
    BLK_C = 3'd0,  // all control
    BLK_S = 3'd1,  // start (lane 0 or lane 4)
    BLK_T = 3'd2,  // terminate
    BLK_D = 3'd3,  // all data
    BLK_E = 3'd4   // not encodable
  } blk_kind_e;

  // Transmit frame state
  typedef enum logic [0:0] {
    TX_C = 1'b0,
    TX_D = 1'b1
  } tx_state_e;

  // Error block payload: control type with all eight codes set to /E/
  function automatic logic [63:0] err_block_payload();
    logic [63:0] p;
    p = '0;
    p[7:0] = BT_CTRL;
    for (int i = 0; i < 8; i++) begin
      p[8 + 7*i +: 7] = CC_ERROR;
    end
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xgmii_ctrl_code_map.sv
`default_nettype none
// ============================================================================
// Module      : xgmii_ctrl_code_map
// Description : Maps one XGMII control character to its 7-bit 64b/66b control
//               code. Unsupported characters map to /E/ with valid low.
// Revision    : 1.0 - initial release
// ============================================================================
module xgmii_ctrl_code_map
  import xgmii_pkg::*;
(
  input  logic [7:0] in_char,
  output logic [6:0] out_code,
  output logic       out_valid
);

  // Character lookup; anything other than idle or error is not encodable
  always_comb begin
    out_code  = CC_ERROR;
    out_valid = 1'b0;
    case (in_char)
      XGMII_IDLE: begin
        out_code  = CC_IDLE;
        out_valid = 1'b1;
      end
      XGMII_ERROR: begin
        out_code  = CC_ERROR;
        out_valid = 1'b1;
      end
      default: begin
        out_code  = CC_ERROR;
        out_valid = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/xgmii_64b66b_encoder.sv
`default_nettype none
// ============================================================================
// Module      : xgmii_64b66b_encoder
// Description : Pairs two 32-bit XGMII words into one 8-lane column and emits
//               an unscrambled Clause-49 64b/66b block. Also registers the
//               downstream ready back to the MAC.
// Revision    : 1.0 - initial release
// ============================================================================
module xgmii_64b66b_encoder
  import xgmii_pkg::*;
#(
  parameter int XGMII_DATA_WIDTH = 32,
  parameter int XGMII_DATA_BYTES = XGMII_DATA_WIDTH / 8,
  parameter int ERR_CNT_WIDTH    = 16
) (
  input  logic                        tx_clk,
  input  logic                        tx_rst,
  input  logic [XGMII_DATA_WIDTH-1:0] in_xgmii_data,
  input  logic [XGMII_DATA_BYTES-1:0] in_xgmii_ctl,
  output logic                        out_xgmii_pcs_ready,
  input  logic                        in_pcs_tx_ready,
  output logic [1:0]                  out_block_header,
  output logic [63:0]                 out_block_data,
  output logic                        out_block_valid,
  output logic [ERR_CNT_WIDTH-1:0]    out_encode_errors
);

  localparam logic [63:0] ERR_PAYLOAD = err_block_payload();

  // Registered state
  logic                        pcs_ready_q, pcs_ready_d;
  logic                        phase_q,     phase_d;
  logic [XGMII_DATA_WIDTH-1:0] lo_data_q,   lo_data_d;
  logic [XGMII_DATA_BYTES-1:0] lo_ctl_q,    lo_ctl_d;
  tx_state_e                   state_q,     state_d;
  logic [1:0]                  hdr_q,       hdr_d;
  logic [63:0]                 blk_q,       blk_d;
  logic                        valid_q,     valid_d;
  logic [ERR_CNT_WIDTH-1:0]    err_cnt_q,   err_cnt_d;

  // Column view: lanes 0-3 from the stored phase-0 word, 4-7 from the live word
  logic [7:0][7:0] w_col_data;
  logic [7:0]      w_col_ctl;
  logic [7:0][6:0] w_codes;
  logic [7:0]      w_code_ok;

  assign w_col_data = {in_xgmii_data, lo_data_q};
  assign w_col_ctl  = {in_xgmii_ctl, lo_ctl_q};

  generate
    for (genvar lane = 0; lane < 8; lane++) begin : g_code_map
      xgmii_ctrl_code_map u_map (
        .in_char  (w_col_data[lane]),
        .out_code (w_codes[lane]),
        .out_valid(w_code_ok[lane])
      );
    end
  endgenerate

  // Column classification and payload assembly
  blk_kind_e   w_kind;
  logic [63:0] w_payload;
  logic        w_code_err;

  always_comb begin
    w_kind     = BLK_E;
    w_payload  = ERR_PAYLOAD;
    w_code_err = 1'b0;
    if (w_col_ctl == 8'h00) begin
      w_kind    = BLK_D;
      w_payload = w_col_data;
    end else if (w_col_ctl == 8'h01 && w_col_data[0] == XGMII_START) begin
      w_kind    = BLK_S;
      w_payload = {w_col_data[7], w_col_data[6], w_col_data[5], w_col_data[4],
                   w_col_data[3], w_col_data[2], w_col_data[1], BT_S0};
    end else if (w_col_ctl == 8'h1F && w_col_data[4] == XGMII_START) begin
      // Four codes, then a 4-bit zero pad, then lanes 5-7
      w_kind     = BLK_S;
      w_payload  = {w_col_data[7], w_col_data[6], w_col_data[5], 4'h0,
                    w_codes[3], w_codes[2], w_codes[1], w_codes[0], BT_S4};
      w_code_err = ~&w_code_ok[3:0];
    end else begin
      // /T/ lane k: data lanes sit at 8+8i, codes after /T/ at 8+7i, pad between
      for (int k = 0; k < 8; k++) begin
        if (w_col_ctl == (8'hFF << k) && w_col_data[k] == XGMII_TERM) begin
          w_kind         = BLK_T;
          w_payload      = '0;
          w_payload[7:0] = BT_TERM[k];
          for (int i = 0; i < 8; i++) begin
            if (i < k) begin
              w_payload[8 + 8*i +: 8] = w_col_data[i];
            end else if (i > k) begin
              w_payload[8 + 7*i +: 7] = w_codes[i];
              if (!w_code_ok[i]) begin
                w_code_err = 1'b1;
              end
            end
          end
        end
      end
      // All-control column that is not a terminate
      if (w_kind == BLK_E && w_col_ctl == 8'hFF) begin
        w_kind     = BLK_C;
        w_payload  = {w_codes, BT_CTRL};
        w_code_err = ~&w_code_ok;
      end
    end
  end

  // Word acceptance, phase tracking, frame state machine and block output
  logic w_emit_err;

  always_comb begin
    pcs_ready_d = in_pcs_tx_ready;
    phase_d     = phase_q;
    lo_data_d   = lo_data_q;
    lo_ctl_d    = lo_ctl_q;
    state_d     = state_q;
    hdr_d       = hdr_q;
    blk_d       = blk_q;
    valid_d     = 1'b0;
    err_cnt_d   = err_cnt_q;
    w_emit_err  = 1'b0;
    if (pcs_ready_q) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        lo_data_d = in_xgmii_data;
        lo_ctl_d  = in_xgmii_ctl;
      end else begin
        valid_d = 1'b1;
        case (state_q)
          TX_C: begin
            case (w_kind)
              BLK_S:   state_d = TX_D;
              BLK_C:   state_d = TX_C;
              default: w_emit_err = 1'b1;
            endcase
          end
          TX_D: begin
            case (w_kind)
              BLK_D:   state_d = TX_D;
              BLK_T:   state_d = TX_C;
              BLK_S:   w_emit_err = 1'b1;
              default: begin
                w_emit_err = 1'b1;
                state_d    = TX_C;
              end
            endcase
          end
          default: state_d = TX_C;
        endcase
        if (w_emit_err) begin
          hdr_d = SYNC_CTRL;
          blk_d = ERR_PAYLOAD;
        end else begin
          hdr_d = (w_kind == BLK_D) ? SYNC_DATA : SYNC_CTRL;
          blk_d = w_payload;
        end
        if ((w_emit_err || w_code_err) && (err_cnt_q != '1)) begin
          err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
        end
      end
    end
  end

  // State registers; reset drops any half-collected column
  always_ff @(posedge tx_clk) begin
    if (tx_rst) begin
      pcs_ready_q <= 1'b0;
      phase_q     <= 1'b0;
      lo_data_q   <= '0;
      lo_ctl_q    <= '0;
      state_q     <= TX_C;
      hdr_q       <= SYNC_CTRL;
      blk_q       <= {56'h0, BT_CTRL};
      valid_q     <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      pcs_ready_q <= pcs_ready_d;
      phase_q     <= phase_d;
      lo_data_q   <= lo_data_d;
      lo_ctl_q    <= lo_ctl_d;
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      blk_q       <= blk_d;
      valid_q     <= valid_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_xgmii_pcs_ready = pcs_ready_q;
  assign out_block_header    = hdr_q;
  assign out_block_data      = blk_q;
  assign out_block_valid     = valid_q;
  assign out_encode_errors   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_xgmii_64b66b_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_xgmii_64b66b_encoder
// Description : Directed self-checking bench for xgmii_64b66b_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xgmii_64b66b_encoder;

  logic        tx_clk = 1'b0;
  logic        tx_rst;
  logic [31:0] in_xgmii_data;
  logic [3:0]  in_xgmii_ctl;
  logic        out_xgmii_pcs_ready;
  logic        in_pcs_tx_ready;
  logic [1:0]  out_block_header;
  logic [63:0] out_block_data;
  logic        out_block_valid;
  logic [15:0] out_encode_errors;

  int checks   = 0;
  int failures = 0;

  localparam logic [63:0] ERR_BLK  = 64'h3C78F1E3C78F1E1E;
  localparam logic [63:0] IDLE_BLK = 64'h000000000000001E;

  xgmii_64b66b_encoder #(
    .XGMII_DATA_WIDTH(32),
    .XGMII_DATA_BYTES(4),
    .ERR_CNT_WIDTH   (16)
  ) dut (
    .tx_clk             (tx_clk),
    .tx_rst             (tx_rst),
    .in_xgmii_data      (in_xgmii_data),
    .in_xgmii_ctl       (in_xgmii_ctl),
    .out_xgmii_pcs_ready(out_xgmii_pcs_ready),
    .in_pcs_tx_ready    (in_pcs_tx_ready),
    .out_block_header   (out_block_header),
    .out_block_data     (out_block_data),
    .out_block_valid    (out_block_valid),
    .out_encode_errors  (out_encode_errors)
  );

  always #5 tx_clk = ~tx_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one word and hold it until the encoder accepts it
  task automatic send_word(input logic [31:0] d, input logic [3:0] c);
    logic rdy;
    rdy = 1'b0;
    @(negedge tx_clk);
    in_xgmii_data = d;
    in_xgmii_ctl  = c;
    for (int n = 0; n < 50; n++) begin
      rdy = out_xgmii_pcs_ready;
      @(posedge tx_clk);
      if (rdy) break;
      @(negedge tx_clk);
    end
    if (!rdy) begin
      checks++;
      failures++;
      $display("FAIL send_word_timeout observed=ready_low expected=accept");
    end
  endtask

  // Send a full column and check the resulting block
  task automatic send_col(input string tag,
                          input logic [31:0] lo, input logic [3:0] clo,
                          input logic [31:0] hi, input logic [3:0] chi,
                          input logic [1:0] exp_hdr, input logic [63:0] exp_data);
    send_word(lo, clo);
    #1;
    check({tag, "_gap"}, {63'h0, out_block_valid}, 64'h0);
    send_word(hi, chi);
    #1;
    check({tag, "_valid"}, {63'h0, out_block_valid}, 64'h1);
    check({tag, "_hdr"}, {62'h0, out_block_header}, {62'h0, exp_hdr});
    check({tag, "_data"}, out_block_data, exp_data);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tx_rst          = 1'b1;
    in_pcs_tx_ready = 1'b1;
    in_xgmii_data   = 32'h07070707;
    in_xgmii_ctl    = 4'hF;
    repeat (3) @(posedge tx_clk);
    #1;
    check("rst_hdr",   {62'h0, out_block_header}, 64'h2);
    check("rst_data",  out_block_data, IDLE_BLK);
    check("rst_valid", {63'h0, out_block_valid}, 64'h0);
    check("rst_err",   {48'h0, out_encode_errors}, 64'h0);
    check("rst_rdy",   {63'h0, out_xgmii_pcs_ready}, 64'h0);
    @(negedge tx_clk);
    tx_rst = 1'b0;

    // Continuous idle
    for (int i = 0; i < 3; i++) begin
      send_col("idle", 32'h07070707, 4'hF, 32'h07070707, 4'hF, 2'b10, IDLE_BLK);
    end
    check("idle_err", {48'h0, out_encode_errors}, 64'h0);

    // Frame with /S/ in lane 0, one data column, /T/ in lane 4
    send_col("s0", 32'h555555FB, 4'h1, 32'hD5555555, 4'h0, 2'b10, 64'hD555555555555578);
    send_col("d0", 32'h04030201, 4'h0, 32'h08070605, 4'h0, 2'b01, 64'h0807060504030201);
    send_col("t4", 32'hDDCCBBAA, 4'h0, 32'h070707FD, 4'hF, 2'b10, 64'h000000DDCCBBAACC);
    // Idle after terminate is legal only if the machine went back to TX_C
    send_col("idle2", 32'h07070707, 4'hF, 32'h07070707, 4'hF, 2'b10, IDLE_BLK);
    check("t4_err", {48'h0, out_encode_errors}, 64'h0);

    // /S/ in lane 4
    send_col("s4", 32'h07070707, 4'hF, 32'h555555FB, 4'h1, 2'b10, 64'h5555550000000033);

    // Three-cycle stall between the two words of a data column
    @(negedge tx_clk);
    in_xgmii_data   = 32'h11111111;
    in_xgmii_ctl    = 4'h0;
    in_pcs_tx_ready = 1'b0;
    check("stall_rdy_pre", {63'h0, out_xgmii_pcs_ready}, 64'h1);
    @(posedge tx_clk);
    @(negedge tx_clk);
    in_xgmii_data = 32'h22222222;
    check("stall_rdy1", {63'h0, out_xgmii_pcs_ready}, 64'h0);
    check("stall_val1", {63'h0, out_block_valid}, 64'h0);
    @(negedge tx_clk);
    check("stall_rdy2", {63'h0, out_xgmii_pcs_ready}, 64'h0);
    check("stall_val2", {63'h0, out_block_valid}, 64'h0);
    @(negedge tx_clk);
    check("stall_rdy3", {63'h0, out_xgmii_pcs_ready}, 64'h0);
    check("stall_val3", {63'h0, out_block_valid}, 64'h0);
    in_pcs_tx_ready = 1'b1;
    @(negedge tx_clk);
    check("stall_rdy4", {63'h0, out_xgmii_pcs_ready}, 64'h1);
    check("stall_val4", {63'h0, out_block_valid}, 64'h0);
    @(posedge tx_clk);
    #1;
    check("stall_valid", {63'h0, out_block_valid}, 64'h1);
    check("stall_hdr",   {62'h0, out_block_header}, 64'h1);
    check("stall_data",  out_block_data, 64'h2222222211111111);

    // /T/ in lane 0 ends the frame
    send_col("t0", 32'h070707FD, 4'hF, 32'h07070707, 4'hF, 2'b10, 64'h0000000000000087);
    check("t0_err", {48'h0, out_encode_errors}, 64'h0);

    // Data outside a frame is an error block
    send_col("derr", 32'h33333333, 4'h0, 32'h44444444, 4'h0, 2'b10, ERR_BLK);
    check("derr_cnt", {48'h0, out_encode_errors}, 64'h1);

    // Saturation at all-ones
    force dut.err_cnt_q = 16'hFFFF;
    #1;
    release dut.err_cnt_q;
    check("sat_pre", {48'h0, out_encode_errors}, 64'hFFFF);
    send_col("sat", 32'h33333333, 4'h0, 32'h44444444, 4'h0, 2'b10, ERR_BLK);
    check("sat_cnt", {48'h0, out_encode_errors}, 64'hFFFF);

    // Reset after the phase-0 word: that half column must be dropped
    send_word(32'h12345678, 4'h0);
    @(negedge tx_clk);
    tx_rst        = 1'b1;
    in_xgmii_data = 32'h07070707;
    in_xgmii_ctl  = 4'hF;
    @(posedge tx_clk);
    #1;
    check("mrst_valid", {63'h0, out_block_valid}, 64'h0);
    check("mrst_err",   {48'h0, out_encode_errors}, 64'h0);
    @(negedge tx_clk);
    tx_rst = 1'b0;
    #1;
    check("mrst_valid2", {63'h0, out_block_valid}, 64'h0);
    send_col("mrst_idle", 32'h07070707, 4'hF, 32'h07070707, 4'hF, 2'b10, IDLE_BLK);
    check("mrst_cnt", {48'h0, out_encode_errors}, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/xgmii_64b66b_encoder.md
Name: xgmii_64b66b_encoder

Overview:
- Downstream neighbour of the TX MAC, first stage of the TX PCS.
- Consumes the 32-bit XGMII stream: 4 lanes per cycle, with a per-lane control flag.
- Pairs two consecutive words into one 8-lane column and emits one Clause-49 64b/66b block: 2-bit sync header plus 64-bit payload, unscrambled. The scrambler and gearbox are separate downstream blocks.
- Generates the PCS ready that throttles the MAC.

Parameters:
- XGMII_DATA_WIDTH, 32, XGMII data width; fixed at 32.
- XGMII_DATA_BYTES, XGMII_DATA_WIDTH/8, number of lanes per word.
- ERR_CNT_WIDTH, 16, width of the saturating encode-error counter.

Ports:
- tx_clk  in  1  TX clock; the block's only clock.
- tx_rst  in  1  synchronous, active-high reset.
- in_xgmii_data  in  32  XGMII data; lane n = bits [8n+7:8n], lane 0 earliest.
- in_xgmii_ctl  in  4  per-lane control flag.
- out_xgmii_pcs_ready  out  1  ready to the MAC.
- in_pcs_tx_ready  in  1  downstream (scrambler) can accept a block.
- out_block_header  out  2  sync header: 2'b01 data, 2'b10 control.
- out_block_data  out  64  block payload; bits [7:0] = block type for control blocks.
- out_block_valid  out  1  one-cycle strobe, one block per strobe.
- out_encode_errors  out  ERR_CNT_WIDTH  saturating count of error blocks emitted.

Behaviour:
- Clocking and reset: one clock (tx_clk); reset is synchronous and active-high (tx_rst).
- Ready and word acceptance:
  - out_xgmii_pcs_ready is in_pcs_tx_ready registered once; reset value 0.
  - A word is accepted on cycle t when out_xgmii_pcs_ready was 1 at cycle t-1. This matches the MAC's registered output.
- Phase:
  - The phase bit toggles per accepted word: phase 0 holds lanes 0-3 of the column, phase 1 holds lanes 4-7.
  - Phase is held while words are not accepted.
  - Reset sets phase to 0.
- Output timing:
  - When the phase-1 word is accepted, the block is encoded. out_block_* are registered, and out_block_valid pulses the next cycle (latency 1 from the second word).
  - out_block_data and out_block_header hold between pulses.
- Reset values:
  - out_block_header = 2'b10.
  - out_block_data = 64'h...00_1E (idle block: type 0x1E, all control codes 0x00).
  - out_block_valid = 0.
  - out_encode_errors = 0.
- Control-code map (7-bit): /I/ 0x07 -> 0x00; /E/ 0xFE -> 0x1E. Any other control character in a C position -> 0x1E, and the block counts as an error.
- Block types (payload order: type byte, then lanes in ascending order):
  - All 8 lanes data -> header 01, payload = lanes 7..0.
  - All control -> type 0x1E.
  - /S/ at lane 0 -> 0x78.
  - Lanes 0-3 control, /S/ at lane 4 -> 0x33, with 4-bit zero pad after the C codes.
  - /T/ at lane k (k = 0..7), lanes before k data, lanes after k control -> type 0x87, 0x99, 0xAA, 0xB4, 0xCC, 0xD2, 0xE1, 0xFF respectively.
  - Any other column -> error block: type 0x1E, all eight codes 0x1E.
- Frame state machine, updated per column:
  - TX_C: S block -> TX_D. D or T block -> error block, stay in TX_C.
  - TX_D: D block -> stay. T block -> TX_C. C block -> error block, then TX_C. S block -> error block, stay in TX_D.
  - Reset -> TX_C.
- Error counter:
  - Increments once per emitted error block; saturates at all-ones.
- Reset mid-column:
  - A partially collected column is discarded. No block is emitted for it.

Decomposition:
- Shared package xgmii_pkg:
  - XGMII characters (07, FB, FD, FE, 9C).
  - 64b/66b sync headers and block-type constants.
  - 7-bit control-code constants.
- This package is shared with tx_mac and the future decoder.
- One sub-module: xgmii_ctrl_code_map, combinational. Maps 8 bits to 7 bits plus a valid flag; instantiated 8 times.

Test Plan:
- Reset released with in_pcs_tx_ready = 1; idle words (07070707, ctl F) continuously -> blocks every 2 cycles, header 10, payload 0x1E followed by 56 zero bits, errors = 0.
- MAC-style frame with start in phase 0: column {FB, 55×6, D5} -> header 10, type 0x78, payload bytes 55 55 55 55 55 55 D5. Next columns -> header 01.
- Start in phase 1: phase-0 word idle, phase-1 word {FB,55,55,55} -> type 0x33, C0-C3 = 0x00.
- Terminate at lane 4: lanes 0-3 data AA BB CC DD, lanes 4-7 FD 07 07 07 -> type 0xCC, data AA BB CC DD, three codes 0x00; state returns to TX_C.
- Data column while in TX_C -> error block (type 0x1E, codes 0x1E); out_encode_errors increments 0 -> 1. Forced at count FFFF -> stays FFFF.
- in_pcs_tx_ready low for 3 cycles mid-frame -> out_xgmii_pcs_ready low 3 cycles, one cycle later. No words lost, no duplicate blocks; phase preserved across the stall.
